// File: rtl/tag_sdpram_pkg.sv
// tag_sdpram_pkg: shared definitions for the tag/metadata simple-dual-port RAM.
//   - state_t        : sweeper/port-control FSM states
//   - params_legal   : parameter legality (lane size 8 or 9, width a whole number of lanes)
//   - calc_be_width  : number of byte lanes for a given word/lane width
//   - lane_merge     : selects the new or old value of one bit by its lane enable;
//                      used by both the array write path and the read bypass
// Optional feature macro used by the top level: TAG_SDPRAM_BYPASS_EN.
package tag_sdpram_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   function automatic bit params_legal(input int data_width, input int byte_size);
      return ((byte_size == 8) || (byte_size == 9)) &&
             (data_width > 0) &&
             ((data_width % byte_size) == 0);
   endfunction

   // Falls back to one lane on illegal input so elaboration can reach the
   // explicit legality error instead of failing on a zero-width port.
   function automatic int calc_be_width(input int data_width, input int byte_size);
      int width;
      if (params_legal(data_width, byte_size)) begin
         width = data_width / byte_size;
      end else begin
         width = 1;
      end
      return width;
   endfunction

   function automatic logic lane_merge(input logic old_bit, input logic new_bit,
                                       input logic lane_en);
      return lane_en ? new_bit : old_bit;
   endfunction

endpackage

// File: rtl/tag_sdpram_core.sv
// tag_sdpram_core: storage array with byte-lane write and registered read.
// No reset anywhere so the array maps onto block RAM; read is read-first
// (a same-edge write to the read address is not visible to that read).
// Ports:
//   clk           clock
//   we/waddr/wdata/wbe  write strobe, address, data, lane enables
//   re/raddr      read strobe and address
//   rdata         registered read word, held while re is low
module tag_sdpram_core
   import tag_sdpram_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16,
   parameter int BYTE_SIZE  = 8,
   parameter int BE_WIDTH   = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [BE_WIDTH-1:0]   wbe,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Byte-lane write: only bits of enabled lanes take the new value.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_WIDTH; b++) begin
            mem[waddr][b] <= lane_merge(mem[waddr][b], wdata[b], wbe[b / BYTE_SIZE]);
         end
      end
   end

   // Registered read port; holds its word between reads.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/tag_sdpram.sv
// tag_sdpram: parametrised single-clock simple-dual-port RAM for tag storage.
// A sweeper writes CLEAR_VALUE to every entry after reset or clear_req; the
// ports are ignored until init_done. Read latency is 1 cycle, or 2 with
// OUTPUT_REG=1. Macro TAG_SDPRAM_BYPASS_EN adds same-address write-to-read
// forwarding (per-lane merge); without it the read returns the old word.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear_req       one-cycle pulse starting a clear sweep (ignored while clearing)
//   init_done       high when the sweep has finished and the ports are open
//   wr_en/wr_addr/wr_data/wr_byte_en   write port with lane enables
//   rd_en/rd_addr   read port
//   rd_data         read word, held between reads
//   rd_valid        one-cycle pulse qualifying rd_data
module tag_sdpram
   import tag_sdpram_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 6,
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    BYTE_SIZE   = 8,
   parameter int                    BE_WIDTH    = calc_be_width(DATA_WIDTH, BYTE_SIZE),
   parameter int                    OUTPUT_REG  = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_req,
   output logic                  init_done,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [BE_WIDTH-1:0]   wr_byte_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   if (!params_legal(DATA_WIDTH, BYTE_SIZE) || (BE_WIDTH != DATA_WIDTH / BYTE_SIZE)) begin : g_bad_params
      $error("tag_sdpram: illegal DATA_WIDTH/BYTE_SIZE/BE_WIDTH combination");
   end

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_r, state_s;
   logic [ADDR_WIDTH-1:0] clr_addr_r;
   logic                  init_done_r;

   logic                  core_we_s, core_re_s;
   logic [ADDR_WIDTH-1:0] core_waddr_s;
   logic [DATA_WIDTH-1:0] core_wdata_s, core_rdata_s, s1_data_s;
   logic [BE_WIDTH-1:0]   core_wbe_s;
   logic                  v1_r;

   // Next-state logic: sweep ends on the edge that writes the last address.
   always_comb begin
      state_s = state_r;
      case (state_r)
         CLEAR: begin
            if (clr_addr_r == LAST_ADDR) state_s = READY;
            else                         state_s = CLEAR;
         end
         READY: begin
            if (clear_req) state_s = CLEAR;
            else           state_s = READY;
         end
         default: state_s = CLEAR;
      endcase
   end

   // State register, sweep address counter and registered init_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= CLEAR;
         clr_addr_r  <= {ADDR_WIDTH{1'b0}};
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         init_done_r <= (state_s == READY);
         if (state_r == CLEAR) clr_addr_r <= clr_addr_r + ADDR_ONE;  // wraps to 0 after LAST_ADDR
         else                  clr_addr_r <= {ADDR_WIDTH{1'b0}};
      end
   end

   assign init_done = init_done_r;

   // Port arbitration: the sweeper owns the array while clearing; a clear
   // request drops a coincident write, but a coincident read still launches.
   always_comb begin
      core_we_s    = 1'b0;
      core_waddr_s = wr_addr;
      core_wdata_s = wr_data;
      core_wbe_s   = wr_byte_en;
      if (state_r == CLEAR) begin
         core_we_s    = !rst;
         core_waddr_s = clr_addr_r;
         core_wdata_s = CLEAR_VALUE;
         core_wbe_s   = {BE_WIDTH{1'b1}};
      end else begin
         core_we_s    = !rst && wr_en && !clear_req;
      end
      core_re_s = !rst && rd_en && (state_r == READY);
   end

   tag_sdpram_core #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_SIZE  (BYTE_SIZE),
      .BE_WIDTH   (BE_WIDTH)
   ) u_core (
      .clk   (clk),
      .we    (core_we_s),
      .waddr (core_waddr_s),
      .wdata (core_wdata_s),
      .wbe   (core_wbe_s),
      .re    (core_re_s),
      .raddr (rd_addr),
      .rdata (core_rdata_s)
   );

   // First read stage valid; reset discards in-flight reads.
   always_ff @(posedge clk) begin
      if (rst) v1_r <= 1'b0;
      else     v1_r <= core_re_s;
   end

`ifdef TAG_SDPRAM_BYPASS_EN
   logic                  byp_hit_r;
   logic [DATA_WIDTH-1:0] byp_data_r;
   logic [BE_WIDTH-1:0]   byp_be_r;

   // Capture a same-address write alongside each read; held with the read word.
   always_ff @(posedge clk) begin
      if (rst) begin
         byp_hit_r  <= 1'b0;
         byp_data_r <= {DATA_WIDTH{1'b0}};
         byp_be_r   <= {BE_WIDTH{1'b0}};
      end else if (core_re_s) begin
         byp_hit_r  <= core_we_s && (core_waddr_s == rd_addr);
         byp_data_r <= wr_data;
         byp_be_r   <= wr_byte_en;
      end else begin
         byp_hit_r  <= byp_hit_r;
      end
   end

   // Overlay forwarded lanes onto the old word returned by the array.
   always_comb begin
      s1_data_s = core_rdata_s;
      for (int b = 0; b < DATA_WIDTH; b++) begin
         s1_data_s[b] = lane_merge(core_rdata_s[b], byp_data_r[b],
                                   byp_hit_r && byp_be_r[b / BYTE_SIZE]);
      end
   end
`else
   assign s1_data_s = core_rdata_s;
`endif

   if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd_data_r;
      logic                  v2_r;

      // Extra output register stage.
      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
            v2_r      <= 1'b0;
         end else begin
            v2_r <= v1_r;
            if (v1_r) rd_data_r <= s1_data_s;
            else      rd_data_r <= rd_data_r;
         end
      end

      assign rd_data  = rd_data_r;
      assign rd_valid = v2_r;
   end else begin : g_no_oreg
      logic have_data_r;

      // The array read register has no reset; mask it until a read lands.
      always_ff @(posedge clk) begin
         if (rst)            have_data_r <= 1'b0;
         else if (core_re_s) have_data_r <= 1'b1;
         else                have_data_r <= have_data_r;
      end

      assign rd_data  = have_data_r ? s1_data_s : {DATA_WIDTH{1'b0}};
      assign rd_valid = v1_r;
   end

endmodule

// File: tb/tb_tag_sdpram.sv
// tb_tag_sdpram: directed self-checking bench for tag_sdpram (default parameters).
// Reads push an expected word and due cycle onto a scoreboard queue; a
// negedge monitor pops and checks every rd_valid pulse.
module tb_tag_sdpram;

   localparam int OREG = 0;

   logic        clk = 1'b0;
   logic        rst, clear_req, wr_en, rd_en;
   logic        init_done, rd_valid;
   logic [5:0]  wr_addr, rd_addr;
   logic [15:0] wr_data, rd_data;
   logic [1:0]  wr_byte_en;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [15:0] data;
      int          due;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   logic [15:0] last_exp;

   tag_sdpram #(.OUTPUT_REG(OREG)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear_req  (clear_req),
      .init_done  (init_done),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_byte_en (wr_byte_en),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_byte_en = be;
   endtask

   task automatic rd(input logic [5:0] a, input logic [15:0] exp, input string tag);
      exp_t e;
      rd_en = 1'b1; rd_addr = a;
      e.data = exp; e.due = cyc + 1 + OREG; e.tag = tag;
      sb_q.push_back(e);
      last_exp = exp;
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && sb_q.size() > 0; i++) tick();
      chk("scoreboard_drained", sb_q.size(), 32'd0);
   endtask

   // Scoreboard monitor: every rd_valid must match the oldest pending read.
   always @(negedge clk) begin
      if (rd_valid) begin
         if (sb_q.size() == 0) begin
            chk("rd_valid_spurious", {31'd0, rd_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.tag, "_latency"}, cyc, e.due);
            chk(e.tag, {16'd0, rd_data}, {16'd0, e.data});
         end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         chk({sb_q[0].tag, "_rd_valid_missing"}, {31'd0, rd_valid}, 32'd1);
         void'(sb_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1; idle();
      wr_addr = 6'd0; wr_data = 16'd0; wr_byte_en = 2'b00; rd_addr = 6'd0;
      last_exp = 16'd0;

      // Reset held 5 cycles.
      repeat (5) tick();
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_data", {16'd0, rd_data}, 32'd0);

      // Sweep: port traffic must be ignored; init_done rises after edge 64.
      rst = 1'b0;
      wr(6'd1, 16'hDEAD, 2'b11);
      rd_en = 1'b1; rd_addr = 6'd1;
      for (int k = 1; k <= 64; k++) begin
         tick();
         chk($sformatf("sweep_init_done_e%0d", k), {31'd0, init_done}, {31'd0, (k == 64)});
         chk("sweep_rd_valid", {31'd0, rd_valid}, 32'd0);
      end
      idle();

      // Every entry cleared.
      for (int a = 0; a < 64; a++) begin
         rd(a[5:0], 16'h0000, $sformatf("clr_rd_%0d", a));
         tick();
      end
      idle();
      drain();

      // Full-word writes then back-to-back readback.
      for (int a = 0; a < 64; a++) begin
         wr(a[5:0], 16'hFFFF - a[15:0], 2'b11);
         tick();
      end
      idle();
      for (int a = 0; a < 64; a++) begin
         rd(a[5:0], 16'hFFFF - a[15:0], $sformatf("b2b_rd_%0d", a));
         tick();
      end
      idle();
      drain();
      repeat (3) tick();
      chk("rd_data_held", {16'd0, rd_data}, {16'd0, last_exp});

      // Partial lane write.
      wr(6'd5, 16'h1234, 2'b11); tick();
      wr(6'd5, 16'hABCD, 2'b01); tick();
      wr(6'd5, 16'h9999, 2'b00); tick();
      idle();
      rd(6'd5, 16'h12CD, "lane_write_a5"); tick();
      idle();
      drain();

      // Same-cycle read and write of one address.
      wr(6'd7, 16'h1111, 2'b11); tick();
      wr(6'd7, 16'h2222, 2'b10);
`ifdef TAG_SDPRAM_BYPASS_EN
      rd(6'd7, 16'h2211, "same_cycle_a7");
`else
      rd(6'd7, 16'h1111, "same_cycle_a7");
`endif
      tick();
      idle();
      rd(6'd7, 16'h2211, "after_same_cycle_a7"); tick();
      idle();
      drain();

      // Clear request with a coincident write (dropped) and read (completes).
      wr(6'd3, 16'h5555, 2'b11);
      clear_req = 1'b1;
      rd(6'd10, 16'hFFF5, "pre_clear_rd_a10");
      tick();
      idle();
      chk("clear_init_done_fall", {31'd0, init_done}, 32'd0);
      for (int k = 1; k <= 64; k++) begin
         tick();
         chk($sformatf("clear_init_done_e%0d", k), {31'd0, init_done}, {31'd0, (k == 64)});
      end
      rd(6'd3, 16'h0000, "post_clear_rd_a3"); tick();
      rd(6'd10, 16'h0000, "post_clear_rd_a10"); tick();
      idle();
      drain();

      // Reset at sweep address 30 restarts the sweep.
      wr(6'd20, 16'h7777, 2'b11); tick();
      idle();
      clear_req = 1'b1; tick();
      clear_req = 1'b0;
      repeat (30) tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      chk("rst_mid_sweep_init_done", {31'd0, init_done}, 32'd0);
      chk("rst_mid_sweep_rd_data", {16'd0, rd_data}, 32'd0);
      for (int k = 1; k <= 64; k++) begin
         tick();
         chk($sformatf("resweep_init_done_e%0d", k), {31'd0, init_done}, {31'd0, (k == 64)});
      end
      rd(6'd20, 16'h0000, "resweep_rd_a20"); tick();
      rd(6'd63, 16'h0000, "resweep_rd_a63"); tick();
      idle();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
